// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB write arbiter: FSM state encoding,
// default widths and the wait-counter width helper.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Counter must be able to hold TIMEOUT_CYCLES itself.
    function automatic int tmo_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first unmasked request found when
// searching upward from ptr with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               valid
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!valid && req[j] && !mask[j]) begin
                valid    = 1'b1;
                idx      = PW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_write_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ writers.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_write_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic                          busy,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDRESS_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("apb_write_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    state_t                   state;
    logic [PW-1:0]            ptr;
    logic [PW-1:0]            cur;
    logic [PW-1:0]            nxt_ptr;
    logic [PW-1:0]            pick_ptr;
    logic [PW-1:0]            pick_idx;
    logic [NUM_REQ-1:0]       pick_mask;
    logic [NUM_REQ-1:0]       pick_grant;
    logic [NUM_REQ-1:0]       cur_hot;
    logic                     pick_valid;
    logic                     finish;
    logic                     timed_out;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    assign cur_hot = NUM_REQ'(1) << cur;
    assign nxt_ptr = (cur == PW'(NUM_REQ - 1)) ? '0 : cur + 1'b1;

    // On the completing ACCESS cycle re-arbitrate as if the pointer had
    // already advanced, with the finishing requester excluded.
    assign pick_ptr  = (state == ACCESS) ? nxt_ptr : ptr;
    assign pick_mask = (state == ACCESS) ? cur_hot : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req   (req),
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) begin
                sel_addr = sel_addr | req_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data = sel_data | req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = tmo_cnt_w(TIMEOUT_CYCLES);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (state == ACCESS) && !PREADY &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign finish = (state == ACCESS) && (PREADY || timed_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cur     <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            done    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= SETUP;
                        cur     <= pick_idx;
                        PADDR   <= sel_addr;
                        PWDATA  <= sel_data;
                        PSEL    <= 1'b1;
                        PWRITE  <= 1'b1;
                        PENABLE <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (finish) begin
                        done    <= cur_hot;
                        // A timeout is the only way to finish with PREADY low.
                        err     <= PREADY ? PSLVERR : 1'b1;
                        ptr     <= nxt_ptr;
                        PENABLE <= 1'b0;
                        if (pick_valid) begin
                            state  <= SETUP;
                            cur    <= pick_idx;
                            PADDR  <= sel_addr;
                            PWDATA <= sel_data;
                        end else begin
                            state  <= IDLE;
                            PSEL   <= 1'b0;
                            PWRITE <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_write_arbiter.sv
// Directed bench for apb_write_arbiter: single write, wait states, fairness,
// slave error, reset mid-transfer and (with APB_ARB_TIMEOUT_EN) timeout.
module tb_apb_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      done;
    logic              err;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic              PREADY;
    logic              PSLVERR;

    logic [AW-1:0] addr_tab [N];
    logic [DW-1:0] data_tab [N];

    int n_cmp = 0;
    int n_err = 0;

    apb_write_arbiter #(
        .NUM_REQ        (N),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_tables();
        for (int k = 0; k < N; k++) begin
            req_addr[k*AW +: AW] = addr_tab[k];
            req_data[k*DW +: DW] = data_tab[k];
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_psel"},    64'(PSEL),    64'h0);
        check({tag, "_penable"}, 64'(PENABLE), 64'h0);
        check({tag, "_pwrite"},  64'(PWRITE),  64'h0);
        check({tag, "_paddr"},   64'(PADDR),   64'h0);
        check({tag, "_pwdata"},  64'(PWDATA),  64'h0);
        check({tag, "_done"},    64'(done),    64'h0);
        check({tag, "_err"},     64'(err),     64'h0);
        check({tag, "_busy"},    64'(busy),    64'h0);
    endtask

    initial begin
        addr_tab[0] = 32'hABBA0000; data_tab[0] = 32'hABCDEF01;
        addr_tab[1] = 32'hCAFE0000; data_tab[1] = 32'h11110001;
        addr_tab[2] = 32'h22220000; data_tab[2] = 32'h22220002;
        addr_tab[3] = 32'h33330000; data_tab[3] = 32'h33330003;
        load_tables();
        rst = 1'b1; req = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        // Reset state
        tick(); tick();
        check_idle_zero("reset");
        rst = 1'b0;

        // Single zero-wait write from requester 0
        PREADY = 1'b1;
        req = 4'b0001;
        tick();
        check("single_setup_psel",    64'(PSEL),    64'h1);
        check("single_setup_penable", 64'(PENABLE), 64'h0);
        check("single_setup_pwrite",  64'(PWRITE),  64'h1);
        check("single_setup_paddr",   64'(PADDR),   64'hABBA0000);
        check("single_setup_pwdata",  64'(PWDATA),  64'hABCDEF01);
        check("single_setup_busy",    64'(busy),    64'h1);
        req_addr[0 +: AW] = 32'h11111111;
        req_data[0 +: DW] = 32'h22222222;
        tick();
        check("single_access_penable", 64'(PENABLE), 64'h1);
        check("single_access_paddr",   64'(PADDR),   64'hABBA0000);
        check("single_access_pwdata",  64'(PWDATA),  64'hABCDEF01);
        check("single_access_done",    64'(done),    64'h0);
        tick();
        check("single_done", 64'(done), 64'h1);
        check("single_err",  64'(err),  64'h0);
        check("single_psel_after", 64'(PSEL), 64'h0);
        req = '0;
        load_tables();
        tick();
        check("single_done_one_cycle", 64'(done), 64'h0);
        check("single_busy_idle",      64'(busy), 64'h0);

        // Wait states on requester 2
        PREADY = 1'b0;
        req = 4'b0100;
        tick();
        check("wait_setup_paddr", 64'(PADDR), 64'h22220000);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wait_penable", 64'(PENABLE), 64'h1);
            check("wait_paddr",   64'(PADDR),   64'h22220000);
            check("wait_done",    64'(done),    64'h0);
            tick();
        end
        check("wait_penable_last", 64'(PENABLE), 64'h1);
        PREADY = 1'b1;
        tick();
        check("wait_done_pulse", 64'(done), 64'b0100);
        check("wait_err",        64'(err),  64'h0);
        req = '0;
        tick();
        check("wait_done_clear", 64'(done), 64'h0);

        // Fairness: pointer back to 0, all four requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            int k;
            k = n % 4;
            check("fair_setup_psel",    64'(PSEL),    64'h1);
            check("fair_setup_penable", 64'(PENABLE), 64'h0);
            check("fair_setup_paddr",   64'(PADDR),   64'(addr_tab[k]));
            check("fair_setup_busy",    64'(busy),    64'h1);
            tick();
            check("fair_access_penable", 64'(PENABLE), 64'h1);
            check("fair_access_psel",    64'(PSEL),    64'h1);
            tick();
            check("fair_done", 64'(done), 64'(4'b0001 << k));
            check("fair_psel_continuous", 64'(PSEL), (n < 4) ? 64'h1 : 64'h0);
            if (n != 0) req[k] = 1'b0;
        end

        // Slave error on requester 1, then requester 2 proceeds
        req = 4'b0110;
        tick();
        check("slverr_setup_paddr", 64'(PADDR), 64'hCAFE0000);
        tick();
        PSLVERR = 1'b1;
        tick();
        check("slverr_done", 64'(done), 64'b0010);
        check("slverr_err",  64'(err),  64'h1);
        check("slverr_next_paddr", 64'(PADDR), 64'h22220000);
        req = 4'b0100;
        PSLVERR = 1'b0;
        tick();
        check("slverr_done_clear", 64'(done), 64'h0);
        check("slverr_err_clear",  64'(err),  64'h0);
        tick();
        check("slverr_next_done", 64'(done), 64'b0100);
        check("slverr_next_err",  64'(err),  64'h0);
        req = '0;
        tick();

        // Reset mid-transfer on requester 3
        PREADY = 1'b0;
        req = 4'b1000;
        tick();
        check("rstmid_setup_paddr", 64'(PADDR), 64'h33330000);
        tick();
        check("rstmid_access", 64'(PENABLE), 64'h1);
        rst = 1'b1;
        tick();
        check_idle_zero("rstmid");
        rst = 1'b0;
        PREADY = 1'b1;
        req = 4'b1010;
        tick();
        check("rstmid_grant1_paddr", 64'(PADDR), 64'hCAFE0000);
        check("rstmid_no_done",      64'(done),  64'h0);
        tick();
        tick();
        check("rstmid_done1", 64'(done), 64'b0010);
        check("rstmid_next_paddr", 64'(PADDR), 64'h33330000);
        req = 4'b1000;
        tick();
        tick();
        check("rstmid_done3", 64'(done), 64'b1000);
        req = '0;
        tick();
        check("rstmid_idle_psel", 64'(PSEL), 64'h0);

`ifdef APB_ARB_TIMEOUT_EN
        // Timeout: slave never responds
        PREADY = 1'b0;
        req = 4'b0001;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            check("tmo_waiting_done",    64'(done),    64'h0);
            check("tmo_waiting_penable", 64'(PENABLE), 64'h1);
            tick();
        end
        check("tmo_done",    64'(done),    64'b0001);
        check("tmo_err",     64'(err),     64'h1);
        check("tmo_psel",    64'(PSEL),    64'h0);
        check("tmo_penable", 64'(PENABLE), 64'h0);
        req = '0;
        tick();
        check("tmo_idle_busy", 64'(busy), 64'h0);
        check("tmo_idle_done", 64'(done), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_write_arbiter.md
# apb_write_arbiter

Round-robin arbiter and sequencer that lets NUM_REQ write requesters share one AMBA APB master port. It latches a granted requester's address and data, drives the APB SETUP/ACCESS phases, waits for PREADY, and returns a per-requester completion pulse with the slave error flag. It sits between the design's internal write sources and the interconnect feeding the APB slaves.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDRESS_WIDTH, 32: width of PADDR and of each requester address.
- DATA_WIDTH, 32: width of PWDATA and of each requester data word.
- TIMEOUT_CYCLES, 16: ACCESS-phase wait limit. Used only with APB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request. The requester holds it high until its done bit pulses.
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses. Requester k occupies slice k.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data. Slice k belongs to requester k.
- done  out  NUM_REQ  one-cycle completion pulse for the granted requester.
- err  out  1  valid only while done is non-zero. Carries PSLVERR, or the timeout error.
- busy  out  1  high in SETUP and ACCESS.
- PSEL, PENABLE, PWRITE  out  1 each  APB control signals.
- PADDR  out  ADDRESS_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY, PSLVERR  in  1 each  slave handshake signals.

## Operation
- State machine: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req bit is high, pick the winner with the round-robin selector and latch its addr/data into PADDR/PWDATA.
  - Go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, PWRITE=1.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - While PREADY=0, stay in ACCESS.
  - When PREADY=1: pulse done[k], set err=PSLVERR, and advance the pointer to (k+1) mod NUM_REQ.
  - In that same completion cycle, re-arbitrate over req with bit k masked. If any other request is pending, go straight to SETUP with the new latch (back-to-back). Otherwise go to IDLE.
- Round-robin pointer:
  - Reset value is 0.
  - Search order is pointer, pointer+1, … with wrap-around at NUM_REQ-1 → 0.
  - A requester is granted at most once per pass while others are waiting.
- Stability:
  - PADDR and PWDATA change only on a latch event.
  - req_addr and req_data changes after the latch are ignored.
- Requester rules:
  - A requester that deasserts req before done is not supported.
  - A transfer in flight always completes.
  - A requester that keeps req high after done is re-arbitrated the next time it comes up in order.
- Reset values (also the result of rst asserted mid-transfer):
  - State IDLE, pointer 0.
  - PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
  - done=0, err=0, busy=0.
  - The aborted transfer never gets a done pulse.
- If PREADY or PSLVERR is high outside ACCESS, it is ignored.

## Timing
- All outputs are registered.
- Minimum latency: req rises at edge 0 → SETUP visible after edge 1 → ACCESS after edge 2. With PREADY=1, done pulses for one cycle after edge 3.
- Each wait-state cycle (PREADY=0) adds one cycle.
- Back-to-back transfers: the next SETUP follows the completing ACCESS cycle with no IDLE gap. Throughput is one transfer per 2 cycles at zero wait states.
- done and err are high for exactly one cycle, in the cycle after the edge that sampled PREADY=1.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A wait counter runs while in ACCESS and clears on entry to ACCESS.
  - If PREADY is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer terminates: done[k] pulses, err=1, PSEL and PENABLE drop, and the pointer advances as normal.
- APB_ARB_TIMEOUT_EN undefined:
  - No counter. ACCESS waits on PREADY indefinitely.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package apb_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - default width constants;
  - the timeout counter width, derived with $clog2(TIMEOUT_CYCLES+1).
- Sub-module rr_pick: purely combinational. Inputs are the req vector, the mask and the pointer; outputs are a one-hot grant, the grant index and a valid flag.
- Top level: FSM, address/data latch, pointer register, optional timeout counter.

## Test plan
- Single write: req=4'b0001, addr0=32'hABBA0000, data0=32'hABCDEF01, PREADY=1. Expect SETUP then ACCESS with PADDR/PWDATA equal to those values, done=4'b0001 on the third cycle after req, err=0.
- Wait states: req[2] with PREADY low for 3 ACCESS cycles. Expect PENABLE held for 4 cycles, PADDR stable throughout, then one done[2] pulse.
- Fairness: all four req held high with PREADY=1. Expect grant order 0, 1, 2, 3, 0, no IDLE between transfers, and PSEL continuously high.
- Slave error: PSLVERR=1 together with PREADY for req[1] (addr 32'hCAFE0000). Expect done[1]=1 and err=1 for one cycle, after which the next requester proceeds.
- Reset mid-transfer: assert rst during ACCESS. Expect all outputs 0 after the next edge, no done pulse, and the pointer back at 0 so that req=4'b1010 grants 1 first.
- Timeout (macro defined, TIMEOUT_CYCLES=16): PREADY held at 0. Expect done[k]=1 and err=1 after 16 ACCESS cycles, then the state returns to IDLE.
